// File: rtl/count_mode_arbiter_pkg.sv
// Shared definitions for the counter-mode arbiter: FSM encoding and counter mode codes.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRELOAD = 2'b01,
    ST_RUN     = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  localparam logic [1:0] A_EVEN = 2'b00;
  localparam logic [1:0] A_ODD  = 2'b01;
  localparam logic [1:0] A_LOAD = 2'b10;
  localparam logic [1:0] A_HOLD = 2'b11;

  // Client 1 drives the odd sequence, client 0 the even one.
  function automatic logic [1:0] mode_for_client(input logic [1:0] grant);
    return grant[1] ? A_ODD : A_EVEN;
  endfunction

endpackage

// File: rtl/count_mode_arbiter_if.sv
// Request/grant bundle between the two counter clients and the arbiter.
interface count_mode_arbiter_if #(parameter int LEN_W = 4);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             load_req;
  logic [3:0]       z_in;
  logic [1:0]       a;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [3:0]       result;
  logic             busy;

  modport master (
    output req, len0, len1, load_req, z_in,
    input  a, gnt, done, result, busy
  );

  modport slave (
    input  req, len0, len1, load_req, z_in,
    output a, gnt, done, result, busy
  );
endinterface

// File: rtl/count_mode_arbiter_rr_arb2.sv
// Two-way round-robin pick; last is the index of the client granted most recently.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // On a tie the client that did not win last time goes next.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/count_mode_arbiter.sv
// Arbitrates ownership of a shared 4-bit counter between an even and an odd client,
// with a preload path that forces the counter to 15.
module count_mode_arbiter
  import count_ctrl_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  count_mode_arbiter_if.slave bus
);

  state_t           state_r;
  logic [LEN_W-1:0] cnt_r;
  logic             last_r;
  logic [1:0]       a_r;
  logic [1:0]       gnt_r;
  logic [1:0]       done_r;
  logic [3:0]       result_r;
  logic             busy_r;

  logic [1:0]       pick_s;
  logic [LEN_W-1:0] len_sel_s;
  logic [LEN_W-1:0] load_cnt_s;
  logic             owner_req_s;

  rr_arb2 u_rr (
    .req  (bus.req),
    .last (last_r),
    .pick (pick_s)
  );

  // Burst length of the picked client (zero means one cycle) and owner request status.
  always_comb begin
    len_sel_s   = pick_s[1] ? bus.len1 : bus.len0;
    load_cnt_s  = (len_sel_s == '0) ? LEN_W'(1) : len_sel_s;
    owner_req_s = |(bus.req & gnt_r);
  end

  // Arbitration FSM; every output is produced from a register updated with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      last_r   <= 1'b1;
      a_r      <= A_HOLD;
      gnt_r    <= 2'b00;
      done_r   <= 2'b00;
      result_r <= 4'd0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (bus.load_req) begin
            state_r <= ST_PRELOAD;
            a_r     <= A_LOAD;
            gnt_r   <= 2'b00;
            busy_r  <= 1'b1;
          end else if (pick_s != 2'b00) begin
            state_r <= ST_RUN;
            gnt_r   <= pick_s;
            a_r     <= mode_for_client(pick_s);
            cnt_r   <= load_cnt_s;
            busy_r  <= 1'b1;
          end else begin
            a_r    <= A_HOLD;
            gnt_r  <= 2'b00;
            busy_r <= 1'b0;
          end
        end
        ST_PRELOAD: begin
          state_r <= ST_IDLE;
          a_r     <= A_HOLD;
          busy_r  <= 1'b0;
        end
        ST_RUN: begin
          cnt_r <= cnt_r - LEN_W'(1);
          // A dropped owner request ends the burst on the same edge as natural expiry.
          if (!owner_req_s || (cnt_r == LEN_W'(1))) begin
            state_r <= ST_RELEASE;
            a_r     <= A_HOLD;
            done_r  <= gnt_r;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_RELEASE: begin
          state_r  <= ST_IDLE;
          result_r <= bus.z_in;
          last_r   <= gnt_r[1];
          gnt_r    <= 2'b00;
          a_r      <= A_HOLD;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          a_r     <= A_HOLD;
          gnt_r   <= 2'b00;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a      = a_r;
  assign bus.gnt    = gnt_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_count_mode_arbiter.sv
// Directed bench for count_mode_arbiter with a behavioural model of the shared counter.
module tb_count_mode_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] z_r = 4'd0;
  int         n_cmp = 0;
  int         n_err = 0;

  count_mode_arbiter_if #(.LEN_W(4)) bus ();

  count_mode_arbiter #(.LEN_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Shared counter driven by the arbiter's mode output
  always @(posedge clk) begin
    case (bus.a)
      2'b00:   z_r <= (z_r + 4'd2) & 4'hE;
      2'b01:   z_r <= (z_r + 4'd2) | 4'h1;
      2'b10:   z_r <= 4'hF;
      default: z_r <= z_r;
    endcase
  end

  assign bus.z_in = z_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req      = 2'b00;
    bus.len0     = 4'd0;
    bus.len1     = 4'd0;
    bus.load_req = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_a", bus.a, 2'b11);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_done", bus.done, 2'b00);
    chk("rst_result", bus.result, 4'd0);
    chk("rst_busy", bus.busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Preload: a=10 for one cycle, counter becomes 15
    bus.load_req = 1'b1;
    @(negedge clk);
    chk("pre_a", bus.a, 2'b10);
    chk("pre_busy", bus.busy, 1'b1);
    chk("pre_gnt", bus.gnt, 2'b00);
    bus.load_req = 1'b0;
    @(negedge clk);
    chk("pre_after_a", bus.a, 2'b11);
    chk("pre_after_busy", bus.busy, 1'b0);
    chk("pre_z", z_r, 4'hF);

    // Client 0 burst of 4: z goes 15 -> 0 -> 2 -> 4 -> 6
    bus.req  = 2'b01;
    bus.len0 = 4'd4;
    @(negedge clk);
    chk("c0_gnt", bus.gnt, 2'b01);
    chk("c0_busy", bus.busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("c0_run_a", bus.a, 2'b00);
      @(negedge clk);
    end
    chk("c0_rel_a", bus.a, 2'b11);
    chk("c0_rel_done", bus.done, 2'b01);
    chk("c0_rel_gnt", bus.gnt, 2'b01);
    chk("c0_rel_busy", bus.busy, 1'b1);
    bus.req = 2'b00;
    @(negedge clk);
    chk("c0_result", bus.result, 4'd6);
    chk("c0_result_model", bus.result, z_r);
    chk("c0_idle_done", bus.done, 2'b00);
    chk("c0_idle_gnt", bus.gnt, 2'b00);
    chk("c0_idle_busy", bus.busy, 1'b0);

    // Client 1 burst of 8 aborted after 3 RUN cycles: z goes 6 -> 9 -> 11 -> 13
    bus.req  = 2'b10;
    bus.len1 = 4'd8;
    @(negedge clk);
    chk("c1_gnt", bus.gnt, 2'b10);
    for (int i = 0; i < 3; i++) begin
      chk("c1_run_a", bus.a, 2'b01);
      if (i == 2) bus.req = 2'b00;
      @(negedge clk);
    end
    chk("c1_abort_a", bus.a, 2'b11);
    chk("c1_abort_done", bus.done, 2'b10);
    chk("c1_abort_gnt", bus.gnt, 2'b10);
    @(negedge clk);
    chk("c1_result", bus.result, 4'hD);
    chk("c1_idle_done", bus.done, 2'b00);
    chk("c1_idle_busy", bus.busy, 1'b0);

    // Continuous tie with length 2: grants alternate 01, 10, 01 with an IDLE gap
    bus.req  = 2'b11;
    bus.len0 = 4'd2;
    bus.len1 = 4'd2;
    @(negedge clk);
    chk("rr1_gnt", bus.gnt, 2'b01);
    @(negedge clk);
    chk("rr1_run_a", bus.a, 2'b00);
    @(negedge clk);
    chk("rr1_done", bus.done, 2'b01);
    @(negedge clk);
    chk("rr_gap1_gnt", bus.gnt, 2'b00);
    chk("rr_gap1_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("rr2_gnt", bus.gnt, 2'b10);
    chk("rr2_a", bus.a, 2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("rr2_done", bus.done, 2'b10);
    @(negedge clk);
    chk("rr_gap2_gnt", bus.gnt, 2'b00);
    @(negedge clk);
    chk("rr3_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    @(negedge clk);
    chk("rr3_abort_done", bus.done, 2'b01);
    @(negedge clk);
    chk("rr3_idle_busy", bus.busy, 1'b0);

    // Preload and request together: PRELOAD first, then client 0 with len 0 (one cycle)
    bus.load_req = 1'b1;
    bus.req      = 2'b01;
    bus.len0     = 4'd0;
    @(negedge clk);
    chk("mix_pre_a", bus.a, 2'b10);
    chk("mix_pre_gnt", bus.gnt, 2'b00);
    bus.load_req = 1'b0;
    @(negedge clk);
    chk("mix_idle_a", bus.a, 2'b11);
    chk("mix_idle_gnt", bus.gnt, 2'b00);
    @(negedge clk);
    chk("mix_gnt", bus.gnt, 2'b01);
    chk("mix_run_a", bus.a, 2'b00);
    @(negedge clk);
    chk("mix_len0_done", bus.done, 2'b01);
    chk("mix_rel_a", bus.a, 2'b11);
    bus.req = 2'b00;
    @(negedge clk);
    chk("mix_result", bus.result, 4'd0);

    // Reset mid-RUN: outputs clear at once, no done, then client 0 wins the tie
    bus.req  = 2'b11;
    bus.len0 = 4'd8;
    bus.len1 = 4'd8;
    @(negedge clk);
    chk("rst_run_gnt", bus.gnt, 2'b10);
    @(negedge clk);
    chk("rst_run_busy", bus.busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_a", bus.a, 2'b11);
    chk("midrst_gnt", bus.gnt, 2'b00);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 2'b00);
    @(negedge clk);
    chk("midrst_nodone", bus.done, 2'b00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_gnt", bus.gnt, 2'b01);
    chk("postrst_a", bus.a, 2'b00);
    bus.req = 2'b00;
    @(negedge clk);
    chk("postrst_done", bus.done, 2'b01);
    @(negedge clk);
    chk("postrst_idle", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
